// File: rtl/kugelblitz_patch_ctrl_pkg.sv
// Shared constants for the kugelblitz byte-patch controller: lane geometry,
// packed rule layout {en, offset, byte} and FSM state encodings.
package kugelblitz_patch_ctrl_pkg;

    localparam int KG_LANE_BITS = 6;
    localparam int KG_BYTE_BITS = 8;

    typedef enum logic [0:0] {
        KG_ST_IDLE     = 1'b0,
        KG_ST_IN_FRAME = 1'b1
    } kg_state_e;

    // Width of one packed rule: enable bit, byte offset, replacement byte.
    function automatic int kg_rule_width(input int offset_width);
        return 1 + offset_width + KG_BYTE_BITS;
    endfunction

endpackage

// File: rtl/kugelblitz_rule_match.sv
// Combinational lane matcher: finds, per output lane of the current beat, the
// lowest-index enabled rule whose offset lands on that lane.
module kugelblitz_rule_match
    import kugelblitz_patch_ctrl_pkg::*;
#(
    parameter int KEEP_WIDTH   = 64,
    parameter int RULE_COUNT   = 4,
    parameter int OFFSET_WIDTH = 12,
    localparam int RULE_W = kg_rule_width(OFFSET_WIDTH),
    localparam int BEAT_W = OFFSET_WIDTH - KG_LANE_BITS,
    localparam int POP_W  = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [RULE_COUNT*RULE_W-1:0] rules,
    input  logic [BEAT_W-1:0]            beat_cnt,
    input  logic                         beat_en,
    input  logic [KEEP_WIDTH-1:0]        keep,
    output logic [KEEP_WIDTH-1:0]        hit,
    output logic [KEEP_WIDTH*8-1:0]      repl,
    output logic [POP_W-1:0]             hit_cnt
);

    // Rules are scanned from the highest index down so the lowest index wins.
    always_comb begin
        logic                    rule_en;
        logic [OFFSET_WIDTH-1:0] rule_off;
        logic [7:0]              rule_byte;
        hit       = '0;
        repl      = '0;
        hit_cnt   = '0;
        rule_en   = 1'b0;
        rule_off  = '0;
        rule_byte = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            for (int r = RULE_COUNT - 1; r >= 0; r--) begin
                rule_en   = rules[r*RULE_W + RULE_W - 1];
                rule_off  = rules[r*RULE_W + KG_BYTE_BITS +: OFFSET_WIDTH];
                rule_byte = rules[r*RULE_W +: KG_BYTE_BITS];
                if (beat_en && keep[k] && rule_en
                    && (rule_off[OFFSET_WIDTH-1:KG_LANE_BITS] == beat_cnt)
                    && (rule_off[KG_LANE_BITS-1:0] == KG_LANE_BITS'(k))) begin
                    hit[k]         = 1'b1;
                    repl[k*8 +: 8] = rule_byte;
                end
            end
            hit_cnt = hit_cnt + POP_W'(hit[k]);
        end
    end

endmodule

// File: rtl/kugelblitz_patch_ctrl.sv
// Byte-patch controller for one 512-bit CMAC AXIS path: shadow/active rule
// tables with frame-boundary commit, beat tracking and a single output register.
module kugelblitz_patch_ctrl
    import kugelblitz_patch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int RULE_COUNT   = 4,
    parameter int OFFSET_WIDTH = 12,
    localparam int IDX_W = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cfg_wr_en,
    input  logic [IDX_W-1:0]        cfg_wr_idx,
    input  logic [OFFSET_WIDTH-1:0] cfg_wr_offset,
    input  logic [7:0]              cfg_wr_byte,
    input  logic                    cfg_wr_rule_en,
    input  logic                    cfg_commit,
    output logic                    cfg_commit_pend,

    output logic [31:0]             stat_frames,
    output logic [31:0]             stat_patches,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);

    localparam int RULE_W = kg_rule_width(OFFSET_WIDTH);
    localparam int TBL_W  = RULE_COUNT * RULE_W;
    localparam int BEAT_W = OFFSET_WIDTH - KG_LANE_BITS;
    localparam int POP_W  = $clog2(KEEP_WIDTH + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    if (DATA_WIDTH != 512) begin : g_bad_data_width
        $error("kugelblitz_patch_ctrl: only DATA_WIDTH=512 is supported");
    end
    if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep_width
        $error("kugelblitz_patch_ctrl: KEEP_WIDTH*8 must equal DATA_WIDTH");
    end
    if (RULE_COUNT < 1 || RULE_COUNT > 16) begin : g_bad_rule_count
        $error("kugelblitz_patch_ctrl: RULE_COUNT must be 1..16");
    end

    kg_state_e               state_q, state_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    beat_ovf_q, beat_ovf_d;
    logic [TBL_W-1:0]        shadow_q, shadow_d;
    logic [TBL_W-1:0]        active_q, active_d;
    logic                    pend_q, pend_d;
    logic [31:0]             frames_q, frames_d;
    logic [31:0]             patches_q, patches_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0]   m_keep_q, m_keep_d;
    logic                    m_last_q, m_last_d;
    logic [USER_WIDTH-1:0]   m_user_q, m_user_d;

    logic                    s_ready;
    logic                    accept;
    logic                    copy_now;
    logic [KEEP_WIDTH-1:0]   lane_hit;
    logic [DATA_WIDTH-1:0]   lane_repl;
    logic [POP_W-1:0]        hit_cnt;
    logic [DATA_WIDTH-1:0]   patched;

    assign s_ready = !m_valid_q || m_axis_tready;
    assign accept  = s_axis_tvalid && s_ready;

    kugelblitz_rule_match #(
        .KEEP_WIDTH   (KEEP_WIDTH),
        .RULE_COUNT   (RULE_COUNT),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_rule_match (
        .rules    (active_q),
        .beat_cnt (beat_cnt_q),
        .beat_en  (!beat_ovf_q),
        .keep     (s_axis_tkeep),
        .hit      (lane_hit),
        .repl     (lane_repl),
        .hit_cnt  (hit_cnt)
    );

    always_comb begin
        patched = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (s_axis_tkeep[k]) begin
                patched[k*8 +: 8] = lane_hit[k] ? lane_repl[k*8 +: 8] : s_axis_tdata[k*8 +: 8];
            end
        end
    end

    // The copy reads shadow_d so a rule written on the copy edge is included.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        beat_ovf_d = beat_ovf_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        pend_d     = pend_q;
        frames_d   = frames_q;
        patches_d  = patches_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        m_user_d   = m_user_q;
        copy_now   = 1'b0;

        for (int r = 0; r < RULE_COUNT; r++) begin
            if (cfg_wr_en && (cfg_wr_idx == IDX_W'(r))) begin
                shadow_d[r*RULE_W +: RULE_W] = {cfg_wr_rule_en, cfg_wr_offset, cfg_wr_byte};
            end
        end

        case (state_q)
            KG_ST_IDLE: begin
                if (accept && !s_axis_tlast) begin
                    state_d = KG_ST_IN_FRAME;
                end
            end
            KG_ST_IN_FRAME: begin
                if (accept && s_axis_tlast) begin
                    state_d = KG_ST_IDLE;
                end
            end
            default: state_d = KG_ST_IDLE;
        endcase

        if (accept) begin
            patches_d = patches_q + 32'(hit_cnt);
            if (s_axis_tlast) begin
                beat_cnt_d = '0;
                beat_ovf_d = 1'b0;
                frames_d   = frames_q + 32'd1;
            end else if (beat_cnt_q == BEAT_MAX) begin
                beat_ovf_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        if (pend_q && (((state_q == KG_ST_IDLE) && !accept) || (accept && s_axis_tlast))) begin
            copy_now = 1'b1;
        end
        if (copy_now) begin
            active_d = shadow_d;
            pend_d   = 1'b0;
        end else if (cfg_commit) begin
            pend_d = 1'b1;
        end

        if (s_ready) begin
            m_valid_d = s_axis_tvalid;
        end
        if (accept) begin
            m_data_d = patched;
            m_keep_d = s_axis_tkeep;
            m_last_d = s_axis_tlast;
            m_user_d = s_axis_tuser;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= KG_ST_IDLE;
            beat_cnt_q <= '0;
            beat_ovf_q <= 1'b0;
            shadow_q   <= '0;
            active_q   <= '0;
            pend_q     <= 1'b0;
            frames_q   <= '0;
            patches_q  <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            beat_ovf_q <= beat_ovf_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            frames_q   <= frames_d;
            patches_q  <= patches_d;
            m_valid_q  <= m_valid_d;
        end
    end

    // Payload is qualified by m_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        m_data_q <= m_data_d;
        m_keep_q <= m_keep_d;
        m_last_q <= m_last_d;
        m_user_q <= m_user_d;
    end

    assign s_axis_tready   = s_ready;
    assign cfg_commit_pend = pend_q;
    assign stat_frames     = frames_q;
    assign stat_patches    = patches_q;
    assign m_axis_tvalid   = m_valid_q;
    assign m_axis_tdata    = m_data_q;
    assign m_axis_tkeep    = m_keep_q;
    assign m_axis_tlast    = m_last_q;
    assign m_axis_tuser    = m_user_q;

endmodule

// File: tb/tb_kugelblitz_patch_ctrl.sv
// Scoreboard bench for kugelblitz_patch_ctrl: a reference patch model predicts
// every output beat and the statistics counters.
module tb_kugelblitz_patch_ctrl;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 1;
    localparam int RC = 4;
    localparam int OW = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_wr_en = 1'b0;
    logic [1:0]     cfg_wr_idx = '0;
    logic [OW-1:0]  cfg_wr_offset = '0;
    logic [7:0]     cfg_wr_byte = '0;
    logic           cfg_wr_rule_en = 1'b0;
    logic           cfg_commit = 1'b0;
    logic           cfg_commit_pend;
    logic [31:0]    stat_frames;
    logic [31:0]    stat_patches;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic [KW-1:0]  s_axis_tkeep = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic           s_axis_tlast = 1'b0;
    logic [UW-1:0]  s_axis_tuser = '0;
    logic [DW-1:0]  m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           m_axis_tlast;
    logic [UW-1:0]  m_axis_tuser;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    beat_t       sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          exp_frames = 0;
    int          exp_patches = 0;
    bit          toggle_mode = 1'b0;
    bit          check_ready_formula = 1'b0;
    logic        sh_en[RC];
    logic [OW-1:0] sh_off[RC];
    logic [7:0]  sh_byte[RC];
    logic        ac_en[RC];
    logic [OW-1:0] ac_off[RC];
    logic [7:0]  ac_byte[RC];

    kugelblitz_patch_ctrl #(
        .DATA_WIDTH   (DW),
        .KEEP_WIDTH   (KW),
        .USER_WIDTH   (UW),
        .RULE_COUNT   (RC),
        .OFFSET_WIDTH (OW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_idx      (cfg_wr_idx),
        .cfg_wr_offset   (cfg_wr_offset),
        .cfg_wr_byte     (cfg_wr_byte),
        .cfg_wr_rule_en  (cfg_wr_rule_en),
        .cfg_commit      (cfg_commit),
        .cfg_commit_pend (cfg_commit_pend),
        .stat_frames     (stat_frames),
        .stat_patches    (stat_patches),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference patch: lowest-index enabled rule whose absolute offset equals beat*64+lane.
    function automatic logic [DW-1:0] refPatch(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                              input int beat, output int hits);
        logic [DW-1:0] res;
        logic          found;
        logic [7:0]    val;
        res  = '0;
        hits = 0;
        for (int lane = 0; lane < KW; lane++) begin
            found = 1'b0;
            val   = 8'h00;
            if (k[lane]) begin
                for (int r = RC - 1; r >= 0; r--) begin
                    if (ac_en[r] && (int'(ac_off[r]) == beat * 64 + lane)) begin
                        found = 1'b1;
                        val   = ac_byte[r];
                    end
                end
                res[lane*8 +: 8] = found ? val : d[lane*8 +: 8];
                if (found) hits++;
            end
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] beatData(input logic [7:0] fill, input int b);
        logic [DW-1:0] d;
        d = {64{fill}};
        d[DW-1 -: 8] = fill ^ 8'(b);
        return d;
    endfunction

    // Monitor at negedge: a beat seen with tready=1 is consumed on the next edge.
    always @(negedge clk) begin
        beat_t exp_beat;
        if (!rst) begin
            if (check_ready_formula) begin
                checkOutput("s_ready_formula", DW'(s_axis_tready), DW'(!m_axis_tvalid || m_axis_tready));
            end
            if (m_axis_tvalid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", DW'(m_axis_tvalid), '0);
                end else if (m_axis_tready) begin
                    exp_beat = sb.pop_front();
                    checkOutput("m_data", m_axis_tdata, exp_beat.data);
                    checkOutput("m_sideband", DW'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                                DW'({exp_beat.keep, exp_beat.last, exp_beat.user}));
                end else begin
                    checkOutput("stall_hold", m_axis_tdata, sb[0].data);
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (toggle_mode) m_axis_tready = ~m_axis_tready;
        else             m_axis_tready = 1'b1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                                 input logic last, input logic [UW-1:0] user, input int beat);
        logic [DW-1:0] exp_data;
        int            hits;
        logic          accepted;
        exp_data      = refPatch(data, keep, beat, hits);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        accepted      = 1'b0;
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            accepted = s_axis_tready;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", DW'(s_axis_tready), DW'(1));
        end else begin
            @(posedge clk);
            sb.push_back('{data: exp_data, keep: keep, last: last, user: user});
            exp_patches += hits;
            if (last) exp_frames++;
        end
        #1;
    endtask

    task automatic sendFrame(input int n, input logic [7:0] fill, input logic [KW-1:0] keep_last);
        for (int b = 0; b < n; b++) begin
            applyStimulus(beatData(fill, b), (b == n - 1) ? keep_last : {KW{1'b1}},
                          b == n - 1, UW'(b), b);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic writeRule(input int idx, input logic en, input int off, input logic [7:0] b,
                             input logic commit);
        cfg_wr_en      = 1'b1;
        cfg_wr_idx     = 2'(idx);
        cfg_wr_offset  = OW'(off);
        cfg_wr_byte    = b;
        cfg_wr_rule_en = en;
        cfg_commit     = commit;
        @(posedge clk);
        #1;
        cfg_wr_en  = 1'b0;
        cfg_commit = 1'b0;
        sh_en[idx]   = en;
        sh_off[idx]  = OW'(off);
        sh_byte[idx] = b;
    endtask

    task automatic commitPulse();
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyActive();
        for (int r = 0; r < RC; r++) begin
            ac_en[r]   = sh_en[r];
            ac_off[r]  = sh_off[r];
            ac_byte[r] = sh_byte[r];
        end
    endtask

    task automatic clearModel();
        for (int r = 0; r < RC; r++) begin
            sh_en[r]   = 1'b0;
            sh_off[r]  = '0;
            sh_byte[r] = '0;
        end
        applyActive();
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (sb.size() != 0 || m_axis_tvalid); c++) @(posedge clk);
        #1;
        checkOutput("drain", DW'(sb.size()), '0);
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, "_frames"}, DW'(stat_frames), DW'(exp_frames));
        checkOutput({tag, "_patches"}, DW'(stat_patches), DW'(exp_patches));
    endtask

    initial begin
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_m_valid", DW'(m_axis_tvalid), '0);
        checkOutput("rst_pend", DW'(cfg_commit_pend), '0);
        checkOutput("rst_s_ready", DW'(s_axis_tready), DW'(1));
        checkStats("rst");

        // Reset mid-frame
        sendFrame(1, 8'h21, {KW{1'b1}});
        for (int b = 0; b < 3; b++) applyStimulus(beatData(8'h42, b), {KW{1'b1}}, 1'b0, UW'(b), b);
        s_axis_tvalid = 1'b0;
        commitPulse();
        checkOutput("midframe_pend", DW'(cfg_commit_pend), DW'(1));
        idleCycles(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_frames  = 0;
        exp_patches = 0;
        clearModel();
        checkOutput("rst2_m_valid", DW'(m_axis_tvalid), '0);
        checkOutput("rst2_pend", DW'(cfg_commit_pend), '0);
        checkStats("rst2");
        sendFrame(2, 8'h3C, {KW{1'b1}});
        drain();
        checkStats("post_rst");

        // Single rule, two-beat frame
        writeRule(0, 1'b1, 10, 8'hAA, 1'b1);
        idleCycles(3);
        applyActive();
        checkOutput("t2_pend", DW'(cfg_commit_pend), '0);
        sendFrame(2, 8'h55, {KW{1'b1}});
        drain();
        checkStats("t2");

        // Commit mid-frame waits for tlast
        applyStimulus(beatData(8'h77, 0), {KW{1'b1}}, 1'b0, UW'(0), 0);
        s_axis_tvalid = 1'b0;
        writeRule(1, 1'b1, 70, 8'hC3, 1'b1);
        checkOutput("t3_pend_set", DW'(cfg_commit_pend), DW'(1));
        applyStimulus(beatData(8'h77, 1), {KW{1'b1}}, 1'b0, UW'(1), 1);
        s_axis_tvalid = 1'b0;
        checkOutput("t3_pend_hold", DW'(cfg_commit_pend), DW'(1));
        applyStimulus(beatData(8'h77, 2), {KW{1'b1}}, 1'b1, UW'(0), 2);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checkOutput("t3_pend_clear", DW'(cfg_commit_pend), '0);
        applyActive();
        sendFrame(2, 8'h77, {KW{1'b1}});
        drain();
        checkStats("t3");

        // Overlapping rules, lane 5 masked then kept
        writeRule(0, 1'b1, 5, 8'h11, 1'b0);
        writeRule(2, 1'b1, 5, 8'h22, 1'b1);
        idleCycles(3);
        applyActive();
        sendFrame(1, 8'h66, ~(64'h1 << 5));
        drain();
        checkStats("t4_masked");
        sendFrame(1, 8'h66, {KW{1'b1}});
        drain();
        checkStats("t4_kept");

        // Backpressure with tready toggling every cycle
        toggle_mode         = 1'b1;
        check_ready_formula = 1'b1;
        sendFrame(4, 8'h5A, {KW{1'b1}});
        drain();
        check_ready_formula = 1'b0;
        toggle_mode         = 1'b0;
        idleCycles(2);
        checkStats("t5");

        // Rule write and commit in the same cycle
        writeRule(0, 1'b1, 0, 8'h33, 1'b1);
        idleCycles(3);
        applyActive();
        checkOutput("t6_pend", DW'(cfg_commit_pend), '0);
        sendFrame(1, 8'h44, {KW{1'b1}});
        drain();
        checkStats("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
